// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, status codes and defaults for the divider sequencer
package div_pkg;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_TMO_CYC = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_DVZ = 2'b01, ST_OVF = 2'b10, ST_TMO = 2'b11} status_t;
endpackage

// File: rtl/div_phase_timer.sv
// div_phase_timer: per-phase cycle counter that expires when the count reaches TMO_CYC-1
module div_phase_timer #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = ($clog2(TMO_CYC) < 1) ? 1 : $clog2(TMO_CYC);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && !expire) cnt <= cnt + CW'(1);
    end
    assign expire = cnt == CW'(TMO_CYC - 1);
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: issues operand pairs to a divider, collects status/quotient and returns a response
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic             div_dvz,
    input  logic             div_ovf,
    input  logic [WIDTH-1:0] div_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [1:0]       rsp_status,
    output logic [7:0]       err_cnt
);
    state_t state, state_nxt;
    status_t rsp_st, set_status;
    logic set_rsp, tmo;
    logic [WIDTH-1:0] set_q;

    div_phase_timer #(.TMO_CYC(TMO_CYC)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state_nxt != state),
        .en(state == ISSUE || state == WAIT_DONE),
        .expire(tmo)
    );

    assign req_ready = state == IDLE;
    assign div_start = state == ISSUE;
    assign rsp_valid = state == RESP;
    assign rsp_status = rsp_st;

    // Divider status only matters in ISSUE/WAIT_DONE; error responses always carry q=0
    always_comb begin
        state_nxt = state;
        set_rsp = 1'b0;
        set_status = ST_OK;
        set_q = '0;
        case (state)
            IDLE: if (req_valid) begin
                state_nxt = (req_b == '0) ? RESP : ISSUE;
                set_rsp = req_b == '0;
                set_status = ST_DVZ;
            end
            ISSUE: if (div_busy) state_nxt = WAIT_DONE;
            else if (tmo) begin
                state_nxt = RESP;
                set_rsp = 1'b1;
                set_status = ST_TMO;
            end
            WAIT_DONE: if (div_ovf || div_dvz || div_valid || tmo) begin
                state_nxt = RESP;
                set_rsp = 1'b1;
                set_status = div_ovf ? ST_OVF : div_dvz ? ST_DVZ : div_valid ? ST_OK : ST_TMO;
                set_q = (!div_ovf && !div_dvz && div_valid) ? div_q : '0;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div_a <= '0;
            div_b <= '0;
            rsp_q <= '0;
            rsp_st <= ST_OK;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (req_valid && req_ready) begin
                div_a <= req_a;
                div_b <= req_b;
            end
            if (set_rsp) begin
                rsp_q <= set_q;
                rsp_st <= set_status;
            end
            if (state == RESP && rsp_ready && rsp_st != ST_OK && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed scenario tasks for div_sequencer with hand-computed expectations
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [9:0] req_a = '0, req_b = '0;
    logic div_start;
    logic [9:0] div_a, div_b;
    logic div_busy = 1'b0, div_valid = 1'b0, div_dvz = 1'b0, div_ovf = 1'b0;
    logic [9:0] div_q = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [9:0] rsp_q;
    logic [1:0] rsp_status;
    logic [7:0] err_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    div_sequencer #(.WIDTH(10), .TMO_CYC(64)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_valid(div_valid), .div_dvz(div_dvz), .div_ovf(div_ovf),
        .div_q(div_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
        .rsp_status(rsp_status), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_cmp++; if (div_start !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ctl got start=%b rsp_valid=%b want 0/0", div_start, rsp_valid); end
        n_cmp++; if (rsp_q !== 10'd0 || rsp_status !== 2'b00) begin n_bad++; $display("FAIL reset_rsp got q=%0d st=%b want 0/00", rsp_q, rsp_status); end
        n_cmp++; if (div_a !== 10'd0 || div_b !== 10'd0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_regs got a=%0d b=%0d err=%0d want 0/0/0", div_a, div_b, err_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_ok();
        req_valid = 1'b1; req_a = 10'd100; req_b = 10'd7; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (div_start !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL ok_issue got start=%b ready=%b want 1/0", div_start, req_ready); end
        n_cmp++; if (div_a !== 10'd100 || div_b !== 10'd7) begin n_bad++; $display("FAIL ok_operands got %0d/%0d want 100/7", div_a, div_b); end
        div_busy = 1'b1;
        @(negedge clk);
        n_cmp++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL ok_start_drop got %b want 0", div_start); end
        for (int i = 0; i < 19; i++) begin
            div_busy = !(i >= 5 && i < 9);
            @(negedge clk);
        end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ok_busy_gap got rsp_valid=%b want 0", rsp_valid); end
        div_busy = 1'b1; div_valid = 1'b1; div_q = 10'd14;
        @(negedge clk);
        div_busy = 1'b0; div_valid = 1'b0; div_q = 10'd0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_q !== 10'd14 || rsp_status !== 2'b00) begin n_bad++; $display("FAIL ok_rsp got v=%b q=%0d st=%b want 1/14/00", rsp_valid, rsp_q, rsp_status); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL ok_done got ready=%b err=%0d want 1/0", req_ready, err_cnt); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_error_priority();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_a = 10'd200; req_b = 10'd3; div_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        div_ovf = 1'b1; div_valid = 1'b1; div_q = 10'd66;
        @(negedge clk);
        div_ovf = 1'b0; div_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_q !== 10'd0) begin n_bad++; $display("FAIL ovf_rsp got v=%b st=%b q=%0d want 1/10/0", rsp_valid, rsp_status, rsp_q); end
        @(negedge clk);
        req_valid = 1'b1; req_a = 10'd40; req_b = 10'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        div_dvz = 1'b1; div_valid = 1'b1; div_q = 10'd10;
        @(negedge clk);
        div_dvz = 1'b0; div_valid = 1'b0; div_busy = 1'b0; div_q = 10'd0;
        n_cmp++; if (rsp_status !== 2'b01 || rsp_q !== 10'd0) begin n_bad++; $display("FAIL dvz_over_valid got st=%b q=%0d want 01/0", rsp_status, rsp_q); end
        @(negedge clk);
        n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL prio_err got %0d want 2", err_cnt); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_dvz();
        req_valid = 1'b1; req_a = 10'd50; req_b = 10'd0;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_q !== 10'd0) begin n_bad++; $display("FAIL dvz_rsp got v=%b st=%b q=%0d want 1/01/0", rsp_valid, rsp_status, rsp_q); end
        n_cmp++; if (div_start !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL dvz_ctl got start=%b ready=%b want 0/0", div_start, req_ready); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || err_cnt !== 8'd3) begin n_bad++; $display("FAIL dvz_done got v=%b err=%0d want 0/3", rsp_valid, err_cnt); end
    endtask

    task automatic test_timeout(input logic busy, input int want_s, input int want_w, input int want_err);
        int s = 0;
        int w = 0;
        bit seen = 0;
        req_valid = 1'b1; req_a = 10'd9; req_b = 10'd2; div_busy = busy;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) seen = 1;
            else if (div_start) s++;
            else w++;
        end
        div_busy = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL tmo_wait no response within 300 cycles"); end
        n_cmp++; if (s !== want_s || w !== want_w) begin n_bad++; $display("FAIL tmo_cycles got start=%0d wait=%0d want %0d/%0d", s, w, want_s, want_w); end
        n_cmp++; if (rsp_status !== 2'b11 || rsp_q !== 10'd0) begin n_bad++; $display("FAIL tmo_rsp got st=%b q=%0d want 11/0", rsp_status, rsp_q); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (err_cnt !== want_err[7:0]) begin n_bad++; $display("FAIL tmo_err got %0d want %0d", err_cnt, want_err); end
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_a = 10'd81; req_b = 10'd9; div_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        div_valid = 1'b1; div_q = 10'd9;
        @(negedge clk);
        div_valid = 1'b0; div_busy = 1'b0; div_q = 10'd0;
        req_valid = 1'b1; req_a = 10'd5; req_b = 10'd0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_q !== 10'd9 || rsp_status !== 2'b00 || req_ready !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold[%0d] got v=%b q=%0d st=%b ready=%b want 1/9/00/0", i, rsp_valid, rsp_q, rsp_status, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || div_b !== 10'd9) begin n_bad++; $display("FAIL stall_release got ready=%b v=%b div_b=%0d want 1/0/9", req_ready, rsp_valid, div_b); end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || div_a !== 10'd5) begin n_bad++; $display("FAIL stall_next got v=%b st=%b div_a=%0d want 1/01/5", rsp_valid, rsp_status, div_a); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (err_cnt !== 8'd6) begin n_bad++; $display("FAIL stall_err got %0d want 6", err_cnt); end
    endtask

    task automatic test_rst_mid();
        req_valid = 1'b1; req_a = 10'd100; req_b = 10'd7; div_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || div_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctl got ready=%b v=%b start=%b want 1/0/0", req_ready, rsp_valid, div_start); end
        n_cmp++; if (err_cnt !== 8'd0 || div_a !== 10'd0) begin n_bad++; $display("FAIL rstmid_regs got err=%0d div_a=%0d want 0/0", err_cnt, div_a); end
        div_valid = 1'b1; div_q = 10'd3;
        repeat (2) @(negedge clk);
        div_valid = 1'b0; div_busy = 1'b0; div_q = 10'd0;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_q !== 10'd0) begin n_bad++; $display("FAIL rstmid_late got v=%b ready=%b q=%0d want 0/1/0", rsp_valid, req_ready, rsp_q); end
    endtask

    task automatic test_saturation();
        req_valid = 1'b1; req_a = 10'd1; req_b = 10'd0; rsp_ready = 1'b1;
        repeat (600) @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL err_saturate got %0d want 255", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_ok();
        test_error_priority();
        test_dvz();
        test_timeout(1'b0, 64, 0, 4);
        test_timeout(1'b1, 1, 64, 5);
        test_stall();
        test_rst_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
